// File: rtl/cpm_topk_pkg.sv
// ---------------------------------------------------------------------------
// cpm_topk_pkg
// Shared types and constants for the CPM streaming top-K selector.
//   topk_state_t : selector FSM states (COLLECT while a frame streams in,
//                  DRAIN while ranked results stream out).
//   TOPK_DESC / TOPK_ASC : ordering mode encodings for cfg_desc.
//   topk_entry_t : layout of one stored entry at the default widths.
//   topk_wins()  : picks the relevant strict comparison for the mode.
// ---------------------------------------------------------------------------
package cpm_topk_pkg;

   typedef enum logic {
      COLLECT = 1'b0,
      DRAIN   = 1'b1
   } topk_state_t;

   localparam logic TOPK_DESC = 1'b1;
   localparam logic TOPK_ASC  = 1'b0;

   // Default key / side-info widths; the top level takes these as its
   // parameter defaults so the entry struct matches an unmodified instance.
   localparam int TOPK_DATA_DW = 8;
   localparam int TOPK_INFO_DW = 8;

   typedef struct packed {
      logic                    vld;
      logic [TOPK_DATA_DW-1:0] dat;
      logic [TOPK_INFO_DW-1:0] inf;
   } topk_entry_t;

   // A new key only wins on a strict comparison, so equal keys never
   // displace an earlier arrival.
   function automatic logic topk_wins(input logic desc, input logic gt, input logic lt);
      return desc ? gt : lt;
   endfunction

endpackage

// File: rtl/cpm_topk_cell.sv
// ---------------------------------------------------------------------------
// cpm_topk_cell
// One slot of the sorted insertion array.
//   clk, rst_n      : clock, asynchronous active-low reset
//   flush           : empty the slot (clear or end of drain)
//   ins             : a beat is being inserted this cycle
//   desc            : ordering mode in force for this beat
//   new_dat/new_inf : incoming key and side info
//   lower_hit       : some lower-index slot already claims the new beat
//   prv_vld/dat/inf : contents of the slot just below (shift source)
//   beats           : this slot would accept the new key
//   vld/dat/inf     : stored entry
// ---------------------------------------------------------------------------
module cpm_topk_cell
   import cpm_topk_pkg::*;
#(
   parameter int DATA_DW = TOPK_DATA_DW,
   parameter int INFO_DW = TOPK_INFO_DW
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               ins,
   input  logic               desc,
   input  logic [DATA_DW-1:0] new_dat,
   input  logic [INFO_DW-1:0] new_inf,
   input  logic               lower_hit,
   input  logic               prv_vld,
   input  logic [DATA_DW-1:0] prv_dat,
   input  logic [INFO_DW-1:0] prv_inf,
   output logic               beats,
   output logic               vld,
   output logic [DATA_DW-1:0] dat,
   output logic [INFO_DW-1:0] inf
);

   logic               vld_reg;
   logic [DATA_DW-1:0] dat_reg;
   logic [INFO_DW-1:0] inf_reg;

   // An empty slot always accepts; valid slots are contiguous from 0,
   // so the first empty one is exactly the append position.
   assign beats = ~vld_reg | topk_wins(desc, new_dat > dat_reg, new_dat < dat_reg);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_reg <= 1'b0;
         dat_reg <= '0;
         inf_reg <= '0;
      end else if (flush) begin
         vld_reg <= 1'b0;
         dat_reg <= '0;
         inf_reg <= '0;
      end else if (ins) begin
         if (lower_hit) begin
            // insert point is below us: move down one rank
            vld_reg <= prv_vld;
            dat_reg <= prv_dat;
            inf_reg <= prv_inf;
         end else if (beats) begin
            vld_reg <= 1'b1;
            dat_reg <= new_dat;
            inf_reg <= new_inf;
         end
      end
   end

   assign vld = vld_reg;
   assign dat = dat_reg;
   assign inf = inf_reg;

endmodule

// File: rtl/cpm_topk_stream.sv
// ---------------------------------------------------------------------------
// cpm_topk_stream
// Streaming top-K selector: collects a frame of (key, info) beats, keeps the
// K best in a sorted insertion array, then drains them in rank order.
//   clk, rst_n        : clock, asynchronous active-low reset
//   clear             : synchronous abort, empties the array
//   cfg_desc          : 1 keep largest K, 0 keep smallest K (frame-latched)
//   in_vld/in_rdy     : input handshake; in_lst marks the frame's last beat
//   in_dat/in_inf     : sort key and side info
//   out_vld/out_rdy   : result handshake; out_lst marks the final result
//   out_dat/out_inf   : ranked key and info, out_rnk its rank (0 = best)
//   topk_cnt          : entries held, saturating at TOPK_K
// ---------------------------------------------------------------------------
module cpm_topk_stream
   import cpm_topk_pkg::*;
#(
   parameter int DATA_DW = TOPK_DATA_DW,
   parameter int INFO_DW = TOPK_INFO_DW,
   parameter int TOPK_K  = 32,
   parameter int TOPK_AW = $clog2(TOPK_K + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               cfg_desc,
   input  logic               in_vld,
   output logic               in_rdy,
   input  logic               in_lst,
   input  logic [DATA_DW-1:0] in_dat,
   input  logic [INFO_DW-1:0] in_inf,
   output logic               out_vld,
   input  logic               out_rdy,
   output logic               out_lst,
   output logic [DATA_DW-1:0] out_dat,
   output logic [INFO_DW-1:0] out_inf,
   output logic [TOPK_AW-1:0] out_rnk,
   output logic [TOPK_AW-1:0] topk_cnt
);

   topk_state_t        state_reg, state_next;
   logic               mode_reg;
   logic [TOPK_AW-1:0] cnt_reg;
   logic [TOPK_AW-1:0] rd_ptr_reg;

   logic accept, out_fire, drain_done, flush, mode_eff, last_rnk;

   logic               beats     [TOPK_K];
   logic [TOPK_K-1:0]  lower_hit;
   logic               ent_vld   [TOPK_K];
   logic [DATA_DW-1:0] ent_dat   [TOPK_K];
   logic [INFO_DW-1:0] ent_inf   [TOPK_K];
   logic               prv_vld   [TOPK_K];
   logic [DATA_DW-1:0] prv_dat   [TOPK_K];
   logic [INFO_DW-1:0] prv_inf   [TOPK_K];

   logic [DATA_DW-1:0] sel_dat;
   logic [INFO_DW-1:0] sel_inf;

   // Handshakes are derived from the state register rather than from the
   // ready/valid outputs so there is no path back through the FSM logic.
   assign accept     = in_vld  & (state_reg == COLLECT) & ~clear;
   assign out_fire   = out_rdy & (state_reg == DRAIN)   & ~clear;
   assign last_rnk   = (rd_ptr_reg == cnt_reg - TOPK_AW'(1));
   assign drain_done = out_fire & last_rnk;
   assign flush      = clear | drain_done;

   // The first beat of a frame must already sort in the new mode.
   assign mode_eff = (cnt_reg == '0) ? cfg_desc : mode_reg;

   // ---------------- insertion array ----------------
   genvar gi;
   generate
      for (gi = 0; gi < TOPK_K; gi++) begin : g_cell
         if (gi == 0) begin : g_head
            assign lower_hit[gi] = 1'b0;
            assign prv_vld[gi]   = 1'b0;
            assign prv_dat[gi]   = '0;
            assign prv_inf[gi]   = '0;
         end else begin : g_body
            // priority chain: set once any lower slot has claimed the beat
            assign lower_hit[gi] = lower_hit[gi-1] | beats[gi-1];
            assign prv_vld[gi]   = ent_vld[gi-1];
            assign prv_dat[gi]   = ent_dat[gi-1];
            assign prv_inf[gi]   = ent_inf[gi-1];
         end

         cpm_topk_cell #(
            .DATA_DW (DATA_DW),
            .INFO_DW (INFO_DW)
         ) u_cell (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush),
            .ins       (accept),
            .desc      (mode_eff),
            .new_dat   (in_dat),
            .new_inf   (in_inf),
            .lower_hit (lower_hit[gi]),
            .prv_vld   (prv_vld[gi]),
            .prv_dat   (prv_dat[gi]),
            .prv_inf   (prv_inf[gi]),
            .beats     (beats[gi]),
            .vld       (ent_vld[gi]),
            .dat       (ent_dat[gi]),
            .inf       (ent_inf[gi])
         );
      end
   endgenerate

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= COLLECT;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      in_rdy     = 1'b0;
      out_vld    = 1'b0;
      case (state_reg)
         COLLECT: begin
            in_rdy = 1'b1;
            if (accept && in_lst) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            out_vld = 1'b1;
            if (drain_done) begin
               state_next = COLLECT;
            end
         end
         default: state_next = COLLECT;
      endcase
      if (clear) begin
         state_next = COLLECT;
      end
   end

   // ---------------- mode, count, read pointer ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_reg   <= TOPK_DESC;
         cnt_reg    <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (accept && (cnt_reg == '0)) begin
            mode_reg <= cfg_desc;
         end

         if (flush) begin
            cnt_reg <= '0;
         end else if (accept && (cnt_reg != TOPK_AW'(TOPK_K))) begin
            cnt_reg <= cnt_reg + TOPK_AW'(1);
         end

         if (flush) begin
            rd_ptr_reg <= '0;
         end else if (out_fire) begin
            rd_ptr_reg <= rd_ptr_reg + TOPK_AW'(1);
         end
      end
   end

   // ---------------- output mux ----------------
   always_comb begin
      sel_dat = '0;
      sel_inf = '0;
      for (int i = 0; i < TOPK_K; i++) begin
         if (rd_ptr_reg == TOPK_AW'(i)) begin
            sel_dat = ent_dat[i];
            sel_inf = ent_inf[i];
         end
      end
   end

   // Result fields read as zero whenever no result is being offered.
   assign out_lst  = out_vld & last_rnk;
   assign out_dat  = out_vld ? sel_dat : '0;
   assign out_inf  = out_vld ? sel_inf : '0;
   assign out_rnk  = out_vld ? rd_ptr_reg : '0;
   assign topk_cnt = cnt_reg;

endmodule

// File: tb/tb_cpm_topk_stream.sv
// ---------------------------------------------------------------------------
// tb_cpm_topk_stream
// Scoreboard bench for cpm_topk_stream with K=4. Each completed frame is
// ranked by an independent selection model and its results queued; every
// output handshake pops and compares one expected result.
// ---------------------------------------------------------------------------
module tb_cpm_topk_stream;

   localparam int K  = 4;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          rst_n, clear, cfg_desc;
   logic          in_vld, in_rdy, in_lst;
   logic [7:0]    in_dat, in_inf;
   logic          out_vld, out_rdy, out_lst;
   logic [7:0]    out_dat, out_inf;
   logic [AW-1:0] out_rnk, topk_cnt;

   typedef struct {
      logic [7:0] dat;
      logic [7:0] inf;
      int         rnk;
      logic       lst;
   } exp_t;

   exp_t       exp_q [$];
   logic [7:0] frame_key [$];
   logic [7:0] frame_inf [$];
   int         exp_cnt;
   int         n_checks = 0;
   int         n_errors = 0;

   always #5 clk = ~clk;

   cpm_topk_stream #(
      .DATA_DW (8),
      .INFO_DW (8),
      .TOPK_K  (K),
      .TOPK_AW (AW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (clear),
      .cfg_desc (cfg_desc),
      .in_vld   (in_vld),
      .in_rdy   (in_rdy),
      .in_lst   (in_lst),
      .in_dat   (in_dat),
      .in_inf   (in_inf),
      .out_vld  (out_vld),
      .out_rdy  (out_rdy),
      .out_lst  (out_lst),
      .out_dat  (out_dat),
      .out_inf  (out_inf),
      .out_rnk  (out_rnk),
      .topk_cnt (topk_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Drives frame_key/frame_inf; cfg_desc is only the requested mode on the
   // first beat, so a design that fails to latch it gets caught.
   task automatic send_frame(input logic desc, input bit with_last);
      int n;
      int m;
      int best;
      int waits;
      bit used [64];
      exp_t e;
      n = frame_key.size();
      for (int i = 0; i < n; i++) begin
         in_vld   = 1'b1;
         in_dat   = frame_key[i];
         in_inf   = frame_inf[i];
         in_lst   = with_last && (i == n - 1);
         cfg_desc = (i == 0) ? desc : ~desc;
         waits = 0;
         while (!in_rdy && waits < 200) begin
            @(posedge clk); #1;
            waits++;
         end
         if (!in_rdy) chk("in_rdy_timeout", 32'(in_rdy), 32'd1);
         @(posedge clk); #1;
      end
      in_vld = 1'b0;
      in_lst = 1'b0;
      if (with_last) begin
         // selection model: repeatedly take the strictly best unused key,
         // scanning in arrival order so ties favour the earlier beat
         m = (n < K) ? n : K;
         for (int j = 0; j < 64; j++) used[j] = 1'b0;
         for (int r = 0; r < m; r++) begin
            best = -1;
            for (int j = 0; j < n; j++) begin
               if (!used[j]) begin
                  if (best < 0) best = j;
                  else if (desc && frame_key[j] > frame_key[best]) best = j;
                  else if (!desc && frame_key[j] < frame_key[best]) best = j;
               end
            end
            used[best] = 1'b1;
            e.dat = frame_key[best];
            e.inf = frame_inf[best];
            e.rnk = r;
            e.lst = (r == m - 1);
            exp_q.push_back(e);
         end
         exp_cnt = m;
      end
   endtask

   // Consumes results; stalls out_rdy for stall_len cycles before handshake
   // number stall_at; stops after max_hs handshakes when max_hs >= 0.
   task automatic drain(input int stall_at, input int stall_len, input int max_hs);
      int   hs = 0;
      int   stall = 0;
      int   cycles = 0;
      logic [7:0]    hold_dat, hold_inf;
      logic [AW-1:0] hold_rnk;
      exp_t e;
      chk("drain_latency_vld", 32'(out_vld), 32'd1);
      chk("drain_cnt", 32'(topk_cnt), 32'(exp_cnt));
      while (exp_q.size() > 0 && cycles < 300 && (max_hs < 0 || hs < max_hs)) begin
         if (out_vld) begin
            chk("drain_in_rdy", 32'(in_rdy), 32'd0);
            if (hs == stall_at && stall < stall_len) begin
               out_rdy = 1'b0;
               if (stall == 0) begin
                  hold_dat = out_dat;
                  hold_inf = out_inf;
                  hold_rnk = out_rnk;
               end else begin
                  chk("stall_dat", 32'(out_dat), 32'(hold_dat));
                  chk("stall_inf", 32'(out_inf), 32'(hold_inf));
                  chk("stall_rnk", 32'(out_rnk), 32'(hold_rnk));
               end
               stall++;
            end else begin
               out_rdy = 1'b1;
               e = exp_q.pop_front();
               $display("result rnk=%0d dat=%0d inf=%0d lst=%0b", out_rnk, out_dat, out_inf, out_lst);
               chk("out_dat", 32'(out_dat), 32'(e.dat));
               chk("out_inf", 32'(out_inf), 32'(e.inf));
               chk("out_rnk", 32'(out_rnk), 32'(e.rnk));
               chk("out_lst", 32'(out_lst), 32'(e.lst));
               hs++;
            end
         end else begin
            out_rdy = 1'b0;
         end
         @(posedge clk); #1;
         cycles++;
      end
      out_rdy = 1'b0;
      if (max_hs < 0) begin
         if (exp_q.size() > 0) begin
            chk("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
         end
         chk("post_in_rdy", 32'(in_rdy), 32'd1);
         chk("post_out_vld", 32'(out_vld), 32'd0);
         chk("post_cnt", 32'(topk_cnt), 32'd0);
      end
   endtask

   task automatic load(input int n, input int k0, input int k1, input int k2, input int k3, input int k4);
      int ks [5];
      ks = '{k0, k1, k2, k3, k4};
      frame_key.delete();
      frame_inf.delete();
      for (int i = 0; i < n; i++) begin
         frame_key.push_back(8'(ks[i]));
         frame_inf.push_back(8'(i));
      end
   endtask

   initial begin
      rst_n = 1'b0; clear = 1'b0; cfg_desc = 1'b1;
      in_vld = 1'b0; in_lst = 1'b0; in_dat = '0; in_inf = '0; out_rdy = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_rdy", 32'(in_rdy), 32'd1);
      chk("rst_out_vld", 32'(out_vld), 32'd0);
      chk("rst_out_lst", 32'(out_lst), 32'd0);
      chk("rst_cnt", 32'(topk_cnt), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // descending with duplicate keys and one dropped beat
      load(5, 5, 9, 2, 9, 7);
      send_frame(1'b1, 1'b1);
      chk("t1_cnt", 32'(topk_cnt), 32'd4);
      drain(-1, 0, -1);

      // ascending with zero keys
      load(3, 0, 0, 3, 0, 0);
      send_frame(1'b0, 1'b1);
      drain(-1, 0, -1);

      // backpressure mid-drain
      load(4, 30, 10, 40, 20, 0);
      send_frame(1'b1, 1'b1);
      drain(2, 3, -1);

      // back-to-back frames: next frame's first beat held waiting during drain
      load(4, 200, 201, 202, 203, 0);
      send_frame(1'b1, 1'b1);
      in_vld = 1'b1; in_dat = 8'd10; in_inf = 8'd0; in_lst = 1'b0; cfg_desc = 1'b1;
      drain(-1, 0, -1);
      load(2, 10, 20, 0, 0, 0);
      send_frame(1'b1, 1'b1);
      drain(-1, 0, -1);

      // clear in COLLECT with a simultaneous beat
      load(3, 1, 2, 3, 0, 0);
      send_frame(1'b1, 1'b0);
      chk("pre_clear_cnt", 32'(topk_cnt), 32'd3);
      clear = 1'b1; in_vld = 1'b1; in_dat = 8'd99;
      @(posedge clk); #1;
      clear = 1'b0; in_vld = 1'b0;
      chk("clr1_cnt", 32'(topk_cnt), 32'd0);
      chk("clr1_out_vld", 32'(out_vld), 32'd0);
      chk("clr1_in_rdy", 32'(in_rdy), 32'd1);

      // clear in DRAIN at rank 1 with a simultaneous handshake
      load(3, 50, 60, 70, 0, 0);
      send_frame(1'b1, 1'b1);
      drain(-1, 0, 1);
      chk("clr2_pre_rnk", 32'(out_rnk), 32'd1);
      clear = 1'b1; out_rdy = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0; out_rdy = 1'b0;
      exp_q.delete();
      chk("clr2_cnt", 32'(topk_cnt), 32'd0);
      chk("clr2_out_vld", 32'(out_vld), 32'd0);
      load(1, 42, 0, 0, 0, 0);
      send_frame(1'b1, 1'b1);
      drain(-1, 0, -1);

      // asynchronous reset mid-drain
      load(3, 11, 22, 33, 0, 0);
      send_frame(1'b0, 1'b1);
      drain(-1, 0, 1);
      #2 rst_n = 1'b0;
      #1;
      exp_q.delete();
      chk("arst_out_vld", 32'(out_vld), 32'd0);
      chk("arst_out_lst", 32'(out_lst), 32'd0);
      chk("arst_out_dat", 32'(out_dat), 32'd0);
      chk("arst_out_inf", 32'(out_inf), 32'd0);
      chk("arst_out_rnk", 32'(out_rnk), 32'd0);
      chk("arst_cnt", 32'(topk_cnt), 32'd0);
      chk("arst_in_rdy", 32'(in_rdy), 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rel_in_rdy", 32'(in_rdy), 32'd1);
      chk("rel_out_vld", 32'(out_vld), 32'd0);
      load(2, 5, 8, 0, 0, 0);
      send_frame(1'b1, 1'b1);
      drain(-1, 0, -1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
